// File: rtl/usr_mem_arbiter_if.sv
// usr_mem_arbiter_if
// Bundles the two requester ports and the datapath command/return signals
// of the round-robin memory arbiter.
//   slave  : arbiter view (requests and read return in, acks and strobes out)
//   master : requester/datapath view (the opposite directions)
// Requester ports per side (a_/b_): req, wr, addr, s, d, msb, lsb in; ack, err out.
// Shared outputs: rdata, busy. Datapath: wr_en, rd_en, addr, S, D, MSBIn, LSBIn out;
// dataout, DataValid in.
interface usr_mem_arbiter_if #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 4
);
    localparam int SELWIDTH = $clog2(DATAWIDTH);

    logic                 a_req, b_req;
    logic                 a_wr, b_wr;
    logic [ADDRWIDTH-1:0] a_addr, b_addr;
    logic [SELWIDTH-1:0]  a_s, b_s;
    logic [DATAWIDTH-1:0] a_d, b_d;
    logic                 a_msb, b_msb, a_lsb, b_lsb;
    logic                 a_ack, b_ack, a_err, b_err;
    logic [DATAWIDTH-1:0] rdata;
    logic                 busy;
    logic                 wr_en, rd_en;
    logic [ADDRWIDTH-1:0] addr;
    logic [SELWIDTH-1:0]  S;
    logic [DATAWIDTH-1:0] D;
    logic                 MSBIn, LSBIn;
    logic [DATAWIDTH-1:0] dataout;
    logic                 DataValid;

    modport slave (
        input  a_req, b_req, a_wr, b_wr, a_addr, b_addr, a_s, b_s, a_d, b_d,
        input  a_msb, b_msb, a_lsb, b_lsb, dataout, DataValid,
        output a_ack, b_ack, a_err, b_err, rdata, busy,
        output wr_en, rd_en, addr, S, D, MSBIn, LSBIn
    );

    modport master (
        output a_req, b_req, a_wr, b_wr, a_addr, b_addr, a_s, b_s, a_d, b_d,
        output a_msb, b_msb, a_lsb, b_lsb, dataout, DataValid,
        input  a_ack, b_ack, a_err, b_err, rdata, busy,
        input  wr_en, rd_en, addr, S, D, MSBIn, LSBIn
    );
endinterface

// File: rtl/usr_mem_arbiter.sv
// usr_mem_arbiter
// Two-requester round-robin arbiter and sequencer for the shift-register/memory
// datapath. Grants one requester, issues its command for one cycle, waits out
// the write latency or the read return (with timeout), then pulses the owner's
// ack (with err and rdata) for one cycle.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : usr_mem_arbiter_if.slave (requesters, datapath command and return)
module usr_mem_arbiter #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 4,
    parameter int WRITE_LAT = 1,
    parameter int READ_LAT  = 2
) (
    input logic              clk,
    input logic              reset,
    usr_mem_arbiter_if.slave bus
);
    localparam int SELWIDTH = $clog2(DATAWIDTH);
    localparam int MAXCOUNT = (WRITE_LAT > READ_LAT + 2) ? WRITE_LAT : READ_LAT + 2;
    localparam int CW       = $clog2(MAXCOUNT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t               state_q, state_d;
    // owner/last_grant encoding: 0 = A, 1 = B
    logic                 owner_q, owner_d;
    logic                 last_q, last_d;
    logic                 is_wr_q, is_wr_d;
    logic [CW-1:0]        cnt_q, cnt_d, cnt_inc;

    logic                 wr_en_q, wr_en_d, rd_en_q, rd_en_d;
    logic [ADDRWIDTH-1:0] addr_q, addr_d;
    logic [SELWIDTH-1:0]  s_q, s_d;
    logic [DATAWIDTH-1:0] d_q, d_d;
    logic                 msb_q, msb_d, lsb_q, lsb_d;
    logic                 a_ack_q, a_ack_d, b_ack_q, b_ack_d;
    logic                 a_err_q, a_err_d, b_err_q, b_err_d;
    logic [DATAWIDTH-1:0] rdata_q, rdata_d;
    logic                 busy_q, busy_d;

    logic                 grant_b, sel_wr, finish, err_flag;

    assign cnt_inc = cnt_q + CW'(1);

    // Every output is a register; the command registers double as the
    // latched command and are loaded on the grant edge so the strobe appears
    // exactly in the ISSUE cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            is_wr_q <= 1'b0;
            cnt_q   <= '0;
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            addr_q  <= '0;
            s_q     <= '0;
            d_q     <= '0;
            msb_q   <= 1'b0;
            lsb_q   <= 1'b0;
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            a_err_q <= 1'b0;
            b_err_q <= 1'b0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            is_wr_q <= is_wr_d;
            cnt_q   <= cnt_d;
            wr_en_q <= wr_en_d;
            rd_en_q <= rd_en_d;
            addr_q  <= addr_d;
            s_q     <= s_d;
            d_q     <= d_d;
            msb_q   <= msb_d;
            lsb_q   <= lsb_d;
            a_ack_q <= a_ack_d;
            b_ack_q <= b_ack_d;
            a_err_q <= a_err_d;
            b_err_q <= b_err_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        is_wr_d  = is_wr_q;
        cnt_d    = cnt_q;
        wr_en_d  = 1'b0;
        rd_en_d  = 1'b0;
        addr_d   = '0;
        s_d      = '0;
        d_d      = '0;
        msb_d    = 1'b0;
        lsb_d    = 1'b0;
        rdata_d  = rdata_q;
        finish   = 1'b0;
        err_flag = 1'b0;
        // On a tie, B wins only if A was granted last.
        grant_b  = bus.b_req && (!bus.a_req || !last_q);
        sel_wr   = grant_b ? bus.b_wr : bus.a_wr;

        case (state_q)
            IDLE: begin
                if (bus.a_req || bus.b_req) begin
                    owner_d = grant_b;
                    last_d  = grant_b;
                    is_wr_d = sel_wr;
                    wr_en_d = sel_wr;
                    rd_en_d = !sel_wr;
                    addr_d  = grant_b ? bus.b_addr : bus.a_addr;
                    msb_d   = grant_b ? bus.b_msb : bus.a_msb;
                    lsb_d   = grant_b ? bus.b_lsb : bus.a_lsb;
                    if (sel_wr) begin
                        s_d = grant_b ? bus.b_s : bus.a_s;
                        d_d = grant_b ? bus.b_d : bus.a_d;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_inc;
                if (is_wr_q) begin
                    finish = (cnt_inc == CW'(WRITE_LAT));
                end else if (bus.DataValid) begin
                    // Data arriving on the timeout cycle still counts as success.
                    finish  = 1'b1;
                    rdata_d = bus.dataout;
                end else if (cnt_inc == CW'(READ_LAT + 2)) begin
                    finish   = 1'b1;
                    err_flag = 1'b1;
                    rdata_d  = '0;
                end
                if (finish) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        a_ack_d = finish && !owner_q;
        b_ack_d = finish && owner_q;
        a_err_d = err_flag && !owner_q;
        b_err_d = err_flag && owner_q;
        busy_d  = (state_d != IDLE);
    end

    assign bus.wr_en = wr_en_q;
    assign bus.rd_en = rd_en_q;
    assign bus.addr  = addr_q;
    assign bus.S     = s_q;
    assign bus.D     = d_q;
    assign bus.MSBIn = msb_q;
    assign bus.LSBIn = lsb_q;
    assign bus.a_ack = a_ack_q;
    assign bus.b_ack = b_ack_q;
    assign bus.a_err = a_err_q;
    assign bus.b_err = b_err_q;
    assign bus.rdata = rdata_q;
    assign bus.busy  = busy_q;
endmodule

// File: tb/tb_usr_mem_arbiter.sv
// tb_usr_mem_arbiter
// Self-checking bench for usr_mem_arbiter. Expected behaviour comes from a
// transaction-level model: who should be granted (round-robin on ties), what
// command must appear in the issue cycle, and on which cycle after the grant
// the ack, err and rdata must appear.
module tb_usr_mem_arbiter;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int WL    = 1;
    localparam int RL    = 2;
    localparam int SW    = $clog2(DW);
    localparam int NO_DV = 99;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    usr_mem_arbiter_if #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) bus ();

    usr_mem_arbiter #(
        .DATAWIDTH(DW),
        .ADDRWIDTH(AW),
        .WRITE_LAT(WL),
        .READ_LAT (RL)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    int            vectors    = 0;
    int            miscompares = 0;
    bit            model_last;
    logic [DW-1:0] model_rdata;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.a_req = 0; bus.b_req = 0; bus.a_wr = 0; bus.b_wr = 0;
        bus.a_addr = '0; bus.b_addr = '0; bus.a_s = '0; bus.b_s = '0;
        bus.a_d = '0; bus.b_d = '0; bus.a_msb = 0; bus.b_msb = 0;
        bus.a_lsb = 0; bus.b_lsb = 0; bus.DataValid = 0; bus.dataout = '0;
    endtask

    task automatic randomize_fields();
        bus.a_wr = 1'($urandom); bus.b_wr = 1'($urandom);
        bus.a_addr = AW'($urandom); bus.b_addr = AW'($urandom);
        bus.a_s = SW'($urandom); bus.b_s = SW'($urandom);
        bus.a_d = DW'($urandom); bus.b_d = DW'($urandom);
        bus.a_msb = 1'($urandom); bus.b_msb = 1'($urandom);
        bus.a_lsb = 1'($urandom); bus.b_lsb = 1'($urandom);
    endtask

    // Runs one transaction starting in an IDLE cycle with requests already
    // driven. dv_delay is the number of cycles after the issue cycle at which
    // the datapath pulses DataValid (NO_DV = never).
    task automatic run_txn(input string tag, input bit release_req,
                           input int dv_delay, input logic [DW-1:0] dv_data);
        bit                         exp_b, exp_wr, exp_err, dv_ok;
        int                         ack_k;
        logic [AW-1:0]              e_addr;
        logic [SW-1:0]              e_s;
        logic [DW-1:0]              e_d, exp_rdata, old_rdata, cur_rdata;
        bit                         e_msb, e_lsb;
        logic [1:0]                 exp_ack, exp_errv;
        logic [AW+SW+DW+1:0]        exp_cmd, got_cmd;

        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL %s idle_busy: got %b expected 0", tag, bus.busy);
        end

        exp_b      = (bus.a_req && bus.b_req) ? !model_last : bus.b_req;
        model_last = exp_b;
        exp_wr     = exp_b ? bus.b_wr : bus.a_wr;
        e_addr     = exp_b ? bus.b_addr : bus.a_addr;
        e_s        = exp_wr ? (exp_b ? bus.b_s : bus.a_s) : '0;
        e_d        = exp_wr ? (exp_b ? bus.b_d : bus.a_d) : '0;
        e_msb      = exp_b ? bus.b_msb : bus.a_msb;
        e_lsb      = exp_b ? bus.b_lsb : bus.a_lsb;
        exp_cmd    = {e_addr, e_s, e_d, e_msb, e_lsb};

        old_rdata = model_rdata;
        dv_ok     = (dv_delay >= 1) && (dv_delay <= RL + 2);
        if (exp_wr) begin
            ack_k = 2 + WL; exp_err = 0; exp_rdata = old_rdata;
        end else if (dv_ok) begin
            ack_k = 2 + dv_delay; exp_err = 0; exp_rdata = dv_data;
        end else begin
            ack_k = 4 + RL; exp_err = 1; exp_rdata = '0;
        end
        model_rdata = exp_rdata;

        for (int k = 1; k <= ack_k; k++) begin
            step();
            vectors++;
            if (bus.busy !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL %s busy k=%0d: got %b expected 1", tag, k, bus.busy);
            end
            got_cmd = {bus.addr, bus.S, bus.D, bus.MSBIn, bus.LSBIn};
            vectors++;
            if (k == 1) begin
                if ({bus.wr_en, bus.rd_en, got_cmd} !== {exp_wr, !exp_wr, exp_cmd}) begin
                    miscompares++;
                    $display("[TB] FAIL %s issue: got wr=%b rd=%b cmd=%h expected wr=%b rd=%b cmd=%h",
                             tag, bus.wr_en, bus.rd_en, got_cmd, exp_wr, !exp_wr, exp_cmd);
                end
            end else if ({bus.wr_en, bus.rd_en, got_cmd} !== '0) begin
                miscompares++;
                $display("[TB] FAIL %s datapath_idle k=%0d: got wr=%b rd=%b cmd=%h expected all 0",
                         tag, k, bus.wr_en, bus.rd_en, got_cmd);
            end
            exp_ack  = (k == ack_k) ? (exp_b ? 2'b01 : 2'b10) : 2'b00;
            exp_errv = (k == ack_k && exp_err) ? exp_ack : 2'b00;
            vectors++;
            if ({bus.a_ack, bus.b_ack, bus.a_err, bus.b_err} !== {exp_ack, exp_errv}) begin
                miscompares++;
                $display("[TB] FAIL %s ack_err k=%0d: got ack=%b%b err=%b%b expected ack=%b err=%b",
                         tag, k, bus.a_ack, bus.b_ack, bus.a_err, bus.b_err, exp_ack, exp_errv);
            end
            cur_rdata = (k == ack_k) ? exp_rdata : old_rdata;
            vectors++;
            if (bus.rdata !== cur_rdata) begin
                miscompares++;
                $display("[TB] FAIL %s rdata k=%0d: got %h expected %h", tag, k, bus.rdata, cur_rdata);
            end

            // Field changes while busy must not disturb the latched command.
            randomize_fields();
            if (exp_wr) bus.DataValid = 1'($urandom);
            else        bus.DataValid = (k == 1 + dv_delay);
            bus.dataout = (bus.DataValid && !exp_wr) ? dv_data : DW'($urandom);
            if (k == ack_k && release_req) begin
                if (exp_b) bus.b_req = 0;
                else       bus.a_req = 0;
            end
        end

        step();
        bus.DataValid = 0;
        vectors++;
        if ({bus.busy, bus.a_ack, bus.b_ack, bus.wr_en, bus.rd_en} !== 5'b0) begin
            miscompares++;
            $display("[TB] FAIL %s back_to_idle: got busy=%b ack=%b%b wr=%b rd=%b expected all 0",
                     tag, bus.busy, bus.a_ack, bus.b_ack, bus.wr_en, bus.rd_en);
        end
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1'b0;
        step();
        step();
        vectors++;
        if ({bus.a_ack, bus.b_ack, bus.a_err, bus.b_err, bus.rdata, bus.busy, bus.wr_en,
             bus.rd_en, bus.addr, bus.S, bus.D, bus.MSBIn, bus.LSBIn} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got busy=%b ack=%b%b rdata=%h wr=%b rd=%b expected all 0",
                     bus.busy, bus.a_ack, bus.b_ack, bus.rdata, bus.wr_en, bus.rd_en);
        end
        reset       = 1'b1;
        model_last  = 1'b1;
        model_rdata = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if ({bus.busy, bus.wr_en, bus.rd_en, bus.a_ack, bus.b_ack} !== 5'b0) begin
                miscompares++;
                $display("[TB] FAIL idle_no_req: got busy=%b wr=%b rd=%b expected 0",
                         bus.busy, bus.wr_en, bus.rd_en);
            end
        end
        randomize_fields();
        bus.a_wr = 1; bus.b_wr = 1; bus.a_addr = 4'd5; bus.b_addr = 4'd9;
        bus.a_req = 1; bus.b_req = 1;
        run_txn("reset_tie_a", 1, 0, '0);
        run_txn("reset_tie_b", 1, 0, '0);
    endtask

    task automatic test_write_a();
        drive_idle();
        bus.a_req = 1; bus.a_wr = 1; bus.a_s = 3'd1; bus.a_d = 8'hA5; bus.a_addr = 4'd3;
        run_txn("write_a", 1, 0, '0);
    endtask

    task automatic test_read_b();
        drive_idle();
        bus.b_req = 1; bus.b_wr = 0; bus.b_addr = 4'd7; bus.b_s = 3'd5; bus.b_d = 8'hFF;
        run_txn("read_b", 1, RL, 8'h3C);
    endtask

    task automatic test_read_timeout();
        drive_idle();
        bus.a_req = 1; bus.a_wr = 0; bus.a_addr = 4'd2;
        run_txn("read_timeout", 1, NO_DV, 8'h77);
    endtask

    task automatic test_dv_boundary();
        drive_idle();
        bus.b_req = 1; bus.b_wr = 0; bus.b_addr = 4'd11;
        run_txn("dv_on_timeout", 1, RL + 2, 8'h5A);
        drive_idle();
        bus.a_req = 1; bus.a_wr = 0; bus.a_addr = 4'd12;
        run_txn("dv_in_issue", 1, 0, 8'hC3);
    endtask

    task automatic test_back_to_back();
        drive_idle();
        bus.a_req = 1; bus.b_req = 1;
        for (int i = 0; i < 4; i++) begin
            randomize_fields();
            run_txn("back_to_back", 0, RL, DW'($urandom));
        end
        drive_idle();
    endtask

    task automatic test_reset_mid_read();
        drive_idle();
        bus.a_req = 1; bus.a_wr = 0; bus.a_addr = 4'd6;
        step();
        step();
        reset = 1'b0;
        #1;
        vectors++;
        if ({bus.a_ack, bus.b_ack, bus.a_err, bus.b_err, bus.rdata, bus.busy, bus.wr_en,
             bus.rd_en, bus.addr, bus.S, bus.D, bus.MSBIn, bus.LSBIn} !== '0) begin
            miscompares++;
            $display("[TB] FAIL mid_reset_outputs: got busy=%b ack=%b%b rdata=%h expected all 0",
                     bus.busy, bus.a_ack, bus.b_ack, bus.rdata);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if ({bus.busy, bus.a_ack, bus.b_ack, bus.wr_en, bus.rd_en} !== 5'b0) begin
                miscompares++;
                $display("[TB] FAIL mid_reset_hold: got busy=%b ack=%b%b expected 0",
                         bus.busy, bus.a_ack, bus.b_ack);
            end
        end
        reset       = 1'b1;
        model_last  = 1'b1;
        model_rdata = '0;
        bus.a_req = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if ({bus.busy, bus.a_ack, bus.b_ack, bus.wr_en, bus.rd_en} !== 5'b0) begin
                miscompares++;
                $display("[TB] FAIL after_reset_idle: got busy=%b ack=%b%b expected 0",
                         bus.busy, bus.a_ack, bus.b_ack);
            end
        end
        bus.b_req = 1; bus.b_wr = 0; bus.b_addr = 4'd13;
        run_txn("after_mid_reset", 1, RL, 8'h96);
    endtask

    task automatic test_random();
        int dly;
        drive_idle();
        for (int i = 0; i < 40; i++) begin
            if (!bus.a_req && ($urandom % 2 == 1)) bus.a_req = 1;
            if (!bus.b_req && ($urandom % 2 == 1)) bus.b_req = 1;
            if (!bus.a_req && !bus.b_req) begin
                if ($urandom % 2 == 1) bus.a_req = 1;
                else                   bus.b_req = 1;
            end
            randomize_fields();
            dly = ($urandom % 5 == 0) ? NO_DV : int'($urandom_range(0, RL + 3));
            run_txn("random", 1, dly, DW'($urandom));
        end
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_write_a();
        test_read_b();
        test_read_timeout();
        test_dv_boundary();
        test_back_to_back();
        test_reset_mid_read();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
